// File: rtl/uart_tx_fifo_drain_if.sv
// Pop-side view of a first-word-fall-through FIFO: the FIFO drives empty/data, the consumer drives read_enable.
interface uart_tx_fifo_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_read_data;
  logic       fifo_read_enable;

  modport master (
    output fifo_empty,
    output fifo_read_data,
    input  fifo_read_enable
  );

  modport slave (
    input  fifo_empty,
    input  fifo_read_data,
    output fifo_read_enable
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Drains an FWFT FIFO into 8N1 UART frames; tx falls one edge after the pop cycle.
// Pops only from IDLE or on the final STOP cycle, so frames run back-to-back with no idle gap.
module uart_tx_fifo_drain #(
  parameter int clocks_per_bit = 868,
  parameter int stop_bits      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_fifo_drain_if.slave  fifo,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(clocks_per_bit);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clocks_per_bit - 1);
  localparam logic [2:0]        STOP_LAST = 3'(stop_bits - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              busy_q;

  logic baud_end;
  logic last_stop;
  logic pop;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign last_stop = (state_q == STOP) && baud_end && (bit_q == STOP_LAST);
  assign pop       = ((state_q == IDLE) || last_stop) && !fifo.fifo_empty && !reset;
  // Counter idles at zero so it is already cleared when a frame starts from IDLE.
  assign baud_d    = ((state_q == IDLE) || baud_end) ? '0 : baud_q + BAUD_W'(1);

  assign fifo.fifo_read_enable = pop;
  assign tx   = tx_q;
  assign busy = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      baud_q <= baud_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            shift_q <= fifo.fifo_read_data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              bit_q   <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (pop) begin
                state_q <= START;
                shift_q <= fifo.fifo_read_data;
                tx_q    <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              // bit_q doubles as the stop-period counter in this state
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: two DUTs (1 and 2 stop bits, 4 clocks per bit) fed by queue-backed FWFT FIFO models.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic clk;
  logic reset;
  logic tx_a, busy_a, tx_b, busy_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       pend_a, pend_b;
  logic       rx_line[$];
  logic [7:0] rx_bytes[$];

  uart_tx_fifo_drain_if ifa ();
  uart_tx_fifo_drain_if ifb ();

  uart_tx_fifo_drain #(.clocks_per_bit(CPB), .stop_bits(1)) dut_a (
    .clk(clk), .reset(reset), .fifo(ifa), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_fifo_drain #(.clocks_per_bit(CPB), .stop_bits(2)) dut_b (
    .clk(clk), .reset(reset), .fifo(ifb), .tx(tx_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO models: apply the pop seen last cycle, present the head, then note this cycle's pop strobe.
  initial begin
    ifa.fifo_empty = 1'b1;
    ifa.fifo_read_data = 8'h00;
    pend_a = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_a && qa.size() != 0) void'(qa.pop_front());
      ifa.fifo_empty = (qa.size() == 0);
      ifa.fifo_read_data = (qa.size() != 0) ? qa[0] : 8'h00;
      #1;
      pend_a = ifa.fifo_read_enable;
    end
  end

  initial begin
    ifb.fifo_empty = 1'b1;
    ifb.fifo_read_data = 8'h00;
    pend_b = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_b && qb.size() != 0) void'(qb.pop_front());
      ifb.fifo_empty = (qb.size() == 0);
      ifb.fifo_read_data = (qb.size() != 0) ? qb[0] : 8'h00;
      #1;
      pend_b = ifb.fifo_read_enable;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Mid-bit sampling receiver over rx_line (one entry per clock).
  task automatic rx_decode(input int sb);
    int j;
    logic [7:0] b;
    rx_bytes = {};
    b = 8'h00;
    j = 1;
    while (j + CPB * (9 + sb) < rx_line.size()) begin
      if (rx_line[j-1] === 1'b1 && rx_line[j] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = rx_line[j + CPB/2 + CPB*(k+1)];
        if (rx_line[j + CPB/2] === 1'b0 && rx_line[j + CPB/2 + CPB*9] === 1'b1)
          rx_bytes.push_back(b);
        j = j + CPB * (9 + sb) - 1;
      end else begin
        j++;
      end
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (ifa.fifo_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", ifa.fifo_read_enable); end
    checks++; if (tx_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b got tx=%b busy=%b want 1/0", tx_b, busy_b); end
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || ifa.fifo_read_enable !== 1'b0)
        begin errors++; $display("FAIL idle_a cyc %0d got tx=%b busy=%b rd=%b want 1/0/0", i, tx_a, busy_a, ifa.fifo_read_enable); end
      checks++; if (tx_b !== 1'b1 || busy_b !== 1'b0 || ifb.fifo_read_enable !== 1'b0)
        begin errors++; $display("FAIL idle_b cyc %0d got tx=%b busy=%b rd=%b want 1/0/0", i, tx_b, busy_b, ifb.fifo_read_enable); end
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    int pops;
    frame = {1'b1, 8'hA5, 1'b0};
    qa.push_back(8'hA5);
    step();
    checks++; if (ifa.fifo_read_enable !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", ifa.fifo_read_enable); end
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ifa.fifo_read_enable === 1'b1) pops++;
      checks++; if (tx_a !== frame[i/4]) begin errors++; $display("FAIL single_tx cyc %0d got %b want %b", i, tx_a, frame[i/4]); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy cyc %0d got %b want 1", i, busy_a); end
    end
    step();
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL single_end got tx=%b busy=%b want 1/0", tx_a, busy_a); end
    checks++; if (pops !== 0) begin errors++; $display("FAIL single_extra_pops got %0d want 0", pops); end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    int pop_at[$];
    int gaps;
    logic [7:0] exp_b[3];
    exp_b = '{8'h00, 8'hFF, 8'h55};
    rx_line = {};
    gaps = 0;
    qa.push_back(8'h00);
    qa.push_back(8'hFF);
    qa.push_back(8'h55);
    for (int i = 1; i <= 125; i++) begin
      step();
      rx_line.push_back(tx_a);
      if (ifa.fifo_read_enable === 1'b1) pop_at.push_back(i);
      if (i >= 2 && i <= 121 && busy_a !== 1'b1) gaps++;
      if (i == 122) begin
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy_a); end
      end
    end
    checks++; if (pop_at.size() != 3) begin errors++; $display("FAIL b2b_pop_count got %0d want 3", pop_at.size()); end
    if (pop_at.size() >= 3) begin
      checks++; if (pop_at[1] - pop_at[0] != 40) begin errors++; $display("FAIL b2b_spacing1 got %0d want 40", pop_at[1] - pop_at[0]); end
      checks++; if (pop_at[2] - pop_at[1] != 40) begin errors++; $display("FAIL b2b_spacing2 got %0d want 40", pop_at[2] - pop_at[1]); end
    end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_busy_gaps got %0d want 0", gaps); end
    rx_decode(1);
    checks++; if (rx_bytes.size() != 3) begin errors++; $display("FAIL b2b_rx_count got %0d want 3", rx_bytes.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= rx_bytes.size()) begin errors++; $display("FAIL b2b_rx_byte%0d got none want %02h", k, exp_b[k]); end
      else if (rx_bytes[k] !== exp_b[k]) begin errors++; $display("FAIL b2b_rx_byte%0d got %02h want %02h", k, rx_bytes[k], exp_b[k]); end
    end
  endtask

  task automatic test_two_stop_bits();
    int pop_at[$];
    int ones;
    rx_line = {};
    qb.push_back(8'h0F);
    qb.push_back(8'h80);
    for (int i = 1; i <= 95; i++) begin
      step();
      rx_line.push_back(tx_b);
      if (ifb.fifo_read_enable === 1'b1) pop_at.push_back(i);
    end
    checks++; if (pop_at.size() != 2) begin errors++; $display("FAIL sb2_pop_count got %0d want 2", pop_at.size()); end
    if (pop_at.size() >= 2) begin
      checks++; if (pop_at[1] - pop_at[0] != 44) begin errors++; $display("FAIL sb2_spacing got %0d want 44", pop_at[1] - pop_at[0]); end
    end
    ones = 0;
    for (int i = 37; i <= 44; i++) if (rx_line[i] === 1'b1) ones++;
    checks++; if (rx_line[36] !== 1'b0) begin errors++; $display("FAIL sb2_bit7 got %b want 0", rx_line[36]); end
    checks++; if (ones != 8) begin errors++; $display("FAIL sb2_stop_len got %0d want 8", ones); end
    checks++; if (rx_line[45] !== 1'b0) begin errors++; $display("FAIL sb2_next_start got %b want 0", rx_line[45]); end
    rx_decode(2);
    checks++; if (rx_bytes.size() != 2) begin errors++; $display("FAIL sb2_rx_count got %0d want 2", rx_bytes.size()); end
    checks++;
    if (rx_bytes.size() < 2) begin errors++; $display("FAIL sb2_rx_bytes got %0d bytes want 0f 80", rx_bytes.size()); end
    else if (rx_bytes[0] !== 8'h0F || rx_bytes[1] !== 8'h80)
      begin errors++; $display("FAIL sb2_rx_bytes got %02h %02h want 0f 80", rx_bytes[0], rx_bytes[1]); end
  endtask

  task automatic test_reset_mid_frame();
    int pops;
    qa.push_back(8'h3C);
    step();
    repeat (18) step();
    checks++; if (busy_a !== 1'b1 || tx_a !== 1'b1) begin errors++; $display("FAIL rst_pre got busy=%b tx=%b want 1/1", busy_a, tx_a); end
    #1 reset = 1'b1;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_async_tx got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b want 0", busy_a); end
    checks++; if (ifa.fifo_read_enable !== 1'b0) begin errors++; $display("FAIL rst_async_rd got %b want 0", ifa.fifo_read_enable); end
    step();
    step();
    #1 reset = 1'b0;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifa.fifo_read_enable === 1'b1) pops++;
      checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_after cyc %0d got tx=%b busy=%b want 1/0", i, tx_a, busy_a); end
    end
    checks++; if (pops != 0) begin errors++; $display("FAIL rst_after_pops got %0d want 0", pops); end
  endtask

  task automatic test_stop_edge_pop();
    qa.push_back(8'h81);
    step();
    checks++; if (ifa.fifo_read_enable !== 1'b1) begin errors++; $display("FAIL edge_first_pop got %b want 1", ifa.fifo_read_enable); end
    repeat (39) step();
    qa.push_back(8'h42);
    step();
    checks++; if (ifa.fifo_read_enable !== 1'b1) begin errors++; $display("FAIL edge_laststop_pop got %b want 1", ifa.fifo_read_enable); end
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL edge_laststop got tx=%b busy=%b want 1/1", tx_a, busy_a); end
    step();
    checks++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL edge_immediate_start got tx=%b busy=%b want 0/1", tx_a, busy_a); end
    repeat (39) step();
    qa.push_back(8'hE7);
    step();
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL edge_idle_gap got tx=%b busy=%b want 1/0", tx_a, busy_a); end
    checks++; if (ifa.fifo_read_enable !== 1'b1) begin errors++; $display("FAIL edge_idle_pop got %b want 1", ifa.fifo_read_enable); end
    step();
    checks++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL edge_late_start got tx=%b busy=%b want 0/1", tx_a, busy_a); end
    repeat (45) step();
    checks++; if (busy_a !== 1'b0 || qa.size() != 0) begin errors++; $display("FAIL edge_drained got busy=%b q=%0d want 0/0", busy_a, qa.size()); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_two_stop_bits();
    test_reset_mid_frame();
    test_stop_edge_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
